key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per display digit slot (min 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port byte_in  input  8  byte from the PS/2 receiver.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe qualifying byte_in.
REQ-006 SHALL have port clear  input  1  synchronous clear of the key history.
REQ-007 SHALL have port led_scancode_debug  output  8  last byte accepted, any value.
REQ-008 SHALL have port make_pulse  output  1  one-cycle strobe per new key press.
REQ-009 SHALL have port break_pulse  output  1  one-cycle strobe per key release.
REQ-010 SHALL have port key_code  output  8  code of the latest make or break event.
REQ-011 SHALL have port key_ext  output  1  latest event carried an E0 prefix.
REQ-012 SHALL have port seven_segment_number  output  4  hex nibble for the active digit.
REQ-013 SHALL have port seven_segment_enable  output  8  active-low one-hot digit enable.

Function
REQ-014 SHALL decode with an FSM of states IDLE, BRK, EXT and EXT_BRK, advancing only on cycles where byte_valid=1.
REQ-015 SHALL go IDLE->BRK on F0, IDLE->EXT on E0, EXT->EXT_BRK on F0, and stay in EXT on E0.
REQ-016 SHALL, in BRK, stay in BRK on F0 and go to EXT_BRK on E0.
REQ-017 SHALL, in EXT_BRK, ignore F0 and E0 and remain in EXT_BRK.
REQ-018 SHALL treat any other byte in IDLE or EXT as a make event, then return to IDLE.
REQ-019 SHALL treat any other byte in BRK or EXT_BRK as a break event, then return to IDLE.
REQ-020 SHALL set key_code and key_ext in the cycle after the completing byte; key_ext=1 only when the sequence came via EXT or EXT_BRK.
REQ-021 SHALL assert break_pulse in the cycle after the byte that completes a break event.
REQ-022 SHALL hold held_code and held_valid registers tracking the key currently pressed.
REQ-023 SHALL, on a make whose code and ext equal held_code while held_valid=1, suppress make_pulse and the history push (typematic repeat).
REQ-024 SHALL, on a new make, assert make_pulse in the cycle after the byte, load held_code and set held_valid.
REQ-025 SHALL clear held_valid on a break whose code matches held_code; other breaks leave it unchanged.
REQ-026 SHALL update led_scancode_debug in the cycle after every byte_valid, prefix bytes included.
REQ-027 SHALL keep a 4-entry history H0..H3 (H0 newest), each with a valid bit.
REQ-028 SHALL, on each make_pulse, shift H0->H1->H2->H3, discard H3, and load H0.
REQ-029 SHALL clear all history valid bits on clear=1; clear takes priority over a push in the same cycle, while the FSM still advances.
REQ-030 SHALL cycle a prescaler 0..SCAN_DIV-1 and advance a 3-bit digit index 0..7 (wrapping 7->0) at each prescaler wrap.
REQ-031 SHALL display digit 2k as Hk[3:0] and digit 2k+1 as Hk[7:4].
REQ-032 SHALL drive seven_segment_enable low only on the bit of the active digit.
REQ-033 SHALL drive seven_segment_enable all-ones when the active digit's entry is invalid.
REQ-034 SHALL drive seven_segment_number to 0 when the active digit's entry is invalid.
REQ-035 SHALL register all outputs; the display outputs lag the digit index by one cycle.

Reset
REQ-036 SHALL, on reset=1 at a clk edge, set the FSM to IDLE and clear the prescaler, digit index, held_valid and all history valid bits.
REQ-037 SHALL, on reset, drive led_scancode_debug=00, key_code=00, key_ext=0, make_pulse=0, break_pulse=0, seven_segment_number=0 and seven_segment_enable=FF.
REQ-038 SHALL give reset priority over byte_valid and clear; a reset mid-sequence (e.g. after F0) discards the partial sequence.

Verification
REQ-039 SHALL cover: bytes 1C, F0, 1C -> make_pulse with key_code=1C, then break_pulse with key_code=1C; H0=1C; digits 0/1 show C/1.
REQ-040 SHALL cover: bytes 1C, 1C, 1C, F0, 1C -> exactly one make_pulse and one break_pulse; history count=1.
REQ-041 SHALL cover: bytes E0, 75, E0, F0, 75 -> make with key_ext=1, key_code=75; break with key_ext=1; led_scancode_debug=75.
REQ-042 SHALL cover: makes 16, 1E, 26, 25, 2E (each released) -> H0..H3=2E,25,26,1E; 16 discarded.
REQ-043 SHALL cover: SCAN_DIV=4 with a single entry 3A -> enable sequence FE, FD, FF x6, repeating every 32 cycles; number A, 3.
REQ-044 SHALL cover: clear=1 in the same cycle as a make-completing byte, and reset between F0 and 1C -> history empty (enable FF); no break_pulse from the interrupted sequence.

Source files
------------

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: PS/2 scancode decoder with typematic filtering, a four-entry
// history of recent key presses, and a multiplexed 8-digit hex display.
module key_event_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       clear,
    output logic [7:0] led_scancode_debug,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic [3:0] seven_segment_number,
    output logic [7:0] seven_segment_enable
);

    localparam int              PRE_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_EXT = 8'hE0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ev_make;
    logic             ev_break;
    logic             ev_ext;
    logic             is_repeat;
    logic             new_make;
    logic             held_match;

    logic [7:0]       held_code;
    logic             held_ext;
    logic             held_valid;

    logic [7:0]       hist_code [4];
    logic [3:0]       hist_vld;

    logic [PRE_W-1:0] pre_cnt;
    logic [2:0]       dig_idx;
    logic [1:0]       dig_ent;
    logic [3:0]       dig_nib;

    // Decode the prefix state machine and classify the completing byte.
    always_comb begin
        state_nxt = state;
        ev_make   = 1'b0;
        ev_break  = 1'b0;
        ev_ext    = 1'b0;
        if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (byte_in == BYTE_BRK)      state_nxt = ST_BRK;
                    else if (byte_in == BYTE_EXT) state_nxt = ST_EXT;
                    else begin
                        ev_make   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (byte_in == BYTE_BRK)      state_nxt = ST_EXT_BRK;
                    else if (byte_in == BYTE_EXT) state_nxt = ST_EXT;
                    else begin
                        ev_make   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (byte_in == BYTE_BRK)      state_nxt = ST_BRK;
                    else if (byte_in == BYTE_EXT) state_nxt = ST_EXT_BRK;
                    else begin
                        ev_break  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    if ((byte_in == BYTE_BRK) || (byte_in == BYTE_EXT)) state_nxt = ST_EXT_BRK;
                    else begin
                        ev_break  = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // A make of the key already held down is auto-repeat and is filtered out.
    always_comb begin
        held_match = (held_code == byte_in) && (held_ext == ev_ext);
        is_repeat  = held_valid && held_match;
        new_make   = ev_make && !is_repeat;
    end

    // Control registers: FSM state, event strobes, latest-event outputs, held flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            make_pulse         <= 1'b0;
            break_pulse        <= 1'b0;
            key_code           <= 8'h00;
            key_ext            <= 1'b0;
            led_scancode_debug <= 8'h00;
            held_valid         <= 1'b0;
        end else begin
            state       <= state_nxt;
            make_pulse  <= new_make;
            break_pulse <= ev_break;
            if (byte_valid) led_scancode_debug <= byte_in;
            if (ev_make || ev_break) begin
                key_code <= byte_in;
                key_ext  <= ev_ext;
            end
            if (new_make)                    held_valid <= 1'b1;
            else if (ev_break && held_match) held_valid <= 1'b0;
        end
    end

    // Identity of the held key; only meaningful while held_valid is set.
    always_ff @(posedge clk) begin
        if (new_make) begin
            held_code <= byte_in;
            held_ext  <= ev_ext;
        end
    end

    // History valid bits: clear wins over a push arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) hist_vld <= 4'b0000;
        else if (new_make)  hist_vld <= {hist_vld[2:0], 1'b1};
    end

    // History codes shift toward H3 on every accepted press.
    always_ff @(posedge clk) begin
        if (new_make) begin
            hist_code[3] <= hist_code[2];
            hist_code[2] <= hist_code[1];
            hist_code[1] <= hist_code[0];
            hist_code[0] <= byte_in;
        end
    end

    // Prescaler paces the digit scan; the digit index steps on each wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            dig_idx <= 3'd0;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
            dig_idx <= dig_idx + 3'd1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Select the nibble for the active digit: even digits low nibble, odd high.
    always_comb begin
        dig_ent = dig_idx[2:1];
        dig_nib = dig_idx[0] ? hist_code[dig_ent][7:4] : hist_code[dig_ent][3:0];
    end

    // Registered display drive; blank digits whose history entry is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            seven_segment_number <= 4'h0;
            seven_segment_enable <= 8'hFF;
        end else if (hist_vld[dig_ent]) begin
            seven_segment_number <= dig_nib;
            seven_segment_enable <= ~(8'd1 << dig_idx);
        end else begin
            seven_segment_number <= 4'h0;
            seven_segment_enable <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed scancode sequences against a byte-level event
// model, with literal spot checks on the decoded events and the display scan.
module tb_key_event_ctrl;

    localparam int S = 4;

    logic       clk;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       clear;
    logic [7:0] led_scancode_debug;
    logic       make_pulse;
    logic       break_pulse;
    logic [7:0] key_code;
    logic       key_ext;
    logic [3:0] seven_segment_number;
    logic [7:0] seven_segment_enable;

    key_event_ctrl #(.SCAN_DIV(S)) dut (
        .clk                  (clk),
        .reset                (reset),
        .byte_in              (byte_in),
        .byte_valid           (byte_valid),
        .clear                (clear),
        .led_scancode_debug   (led_scancode_debug),
        .make_pulse           (make_pulse),
        .break_pulse          (break_pulse),
        .key_code             (key_code),
        .key_ext              (key_ext),
        .seven_segment_number (seven_segment_number),
        .seven_segment_enable (seven_segment_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       started = 1'b0;
    logic       m_brk, m_ext;
    logic       h_valid, h_ext;
    logic [7:0] h_code;
    logic [7:0] hq[$];
    int         ticks;
    logic [7:0] e_led, e_code;
    logic       e_mk, e_bk, e_ext;
    logic [3:0] e_num;
    logic [7:0] e_en;

    always @(posedge clk) begin
        int d;
        int k;
        logic [7:0] b;
        if (reset) begin
            started = 1'b1;
            m_brk = 0; m_ext = 0; h_valid = 0; h_ext = 0; h_code = 0;
            hq.delete();
            ticks = 0;
            e_led = 0; e_code = 0; e_mk = 0; e_bk = 0; e_ext = 0;
            e_num = 0; e_en = 8'hFF;
        end else if (started) begin
            d = (ticks / S) % 8;
            k = d / 2;
            if (k < hq.size()) begin
                e_en  = ~(8'd1 << d);
                b     = hq[k];
                e_num = (d % 2 == 1) ? b[7:4] : b[3:0];
            end else begin
                e_en  = 8'hFF;
                e_num = 4'h0;
            end
            ticks++;
            e_mk = 0;
            e_bk = 0;
            if (byte_valid) begin
                b     = byte_in;
                e_led = b;
                if (b == 8'hF0)      m_brk = 1;
                else if (b == 8'hE0) m_ext = 1;
                else begin
                    e_code = b;
                    e_ext  = m_ext;
                    if (!m_brk) begin
                        if (!(h_valid && h_code == b && h_ext == m_ext)) begin
                            e_mk    = 1;
                            h_valid = 1;
                            h_code  = b;
                            h_ext   = m_ext;
                            hq.push_front(b);
                            if (hq.size() > 4) void'(hq.pop_back());
                        end
                    end else begin
                        e_bk = 1;
                        if (h_valid && h_code == b && h_ext == m_ext) h_valid = 0;
                    end
                    m_brk = 0;
                    m_ext = 0;
                end
            end
            if (clear) hq.delete();
        end
        #1;
        if (started) begin
            check("led_scancode_debug", led_scancode_debug, e_led);
            check("make_pulse", {7'd0, make_pulse}, {7'd0, e_mk});
            check("break_pulse", {7'd0, break_pulse}, {7'd0, e_bk});
            check("key_code", key_code, e_code);
            check("key_ext", {7'd0, key_ext}, {7'd0, e_ext});
            check("seg_number", {4'd0, seven_segment_number}, {4'd0, e_num});
            check("seg_enable", seven_segment_enable, e_en);
        end
    end

    // ---------------- stimulus helpers ----------------
    int mk_seen = 0;
    int bk_seen = 0;
    always @(negedge clk) begin
        if (make_pulse === 1'b1)  mk_seen++;
        if (break_pulse === 1'b1) bk_seen++;
    end

    task automatic send(input logic [7:0] b, input logic clr);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        clear      = clr;
        @(negedge clk);
        byte_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_en(input logic [7:0] t, input string name);
        int n;
        n = 0;
        while (seven_segment_enable !== t && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (seven_segment_enable !== t) check({name, "_timeout"}, seven_segment_enable, t);
    endtask

    task automatic count_blank(input int exp_ff, input string name);
        int ff;
        ff = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (seven_segment_enable === 8'hFF) ff++;
        end
        check(name, 8'(ff), 8'(exp_ff));
    endtask

    logic [7:0] press [5];
    logic [3:0] digs  [8];

    initial begin
        int mk0, bk0;
        int fe, fd, ff;
        reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; clear = 1'b0;
        idle(2);
        reset = 1'b0;
        check("reset_enable", seven_segment_enable, 8'hFF);
        check("reset_key_code", key_code, 8'h00);
        check("reset_led", led_scancode_debug, 8'h00);

        // basic make / break of 1C
        send(8'h1C, 1'b0);
        check("s1_make", {7'd0, make_pulse}, 8'h01);
        check("s1_make_code", key_code, 8'h1C);
        send(8'hF0, 1'b0);
        check("s1_f0_led", led_scancode_debug, 8'hF0);
        check("s1_f0_nobreak", {7'd0, break_pulse}, 8'h00);
        send(8'h1C, 1'b0);
        check("s1_break", {7'd0, break_pulse}, 8'h01);
        check("s1_break_code", key_code, 8'h1C);
        wait_en(8'hFE, "s1_dig0");
        check("s1_dig0_num", {4'd0, seven_segment_number}, 8'h0C);
        wait_en(8'hFD, "s1_dig1");
        check("s1_dig1_num", {4'd0, seven_segment_number}, 8'h01);

        // typematic repeat filtered
        do_reset();
        mk0 = mk_seen; bk0 = bk_seen;
        send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        idle(1);
        check("s2_make_count", 8'(mk_seen - mk0), 8'd1);
        check("s2_break_count", 8'(bk_seen - bk0), 8'd1);
        count_blank(24, "s2_blank_cycles");

        // extended key
        do_reset();
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        check("s3_make", {7'd0, make_pulse}, 8'h01);
        check("s3_make_ext", {7'd0, key_ext}, 8'h01);
        check("s3_make_code", key_code, 8'h75);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        check("s3_break", {7'd0, break_pulse}, 8'h01);
        check("s3_break_ext", {7'd0, key_ext}, 8'h01);
        check("s3_led", led_scancode_debug, 8'h75);

        // history overflow
        do_reset();
        press = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        foreach (press[i]) begin
            send(press[i], 1'b0);
            send(8'hF0, 1'b0);
            send(press[i], 1'b0);
        end
        digs = '{4'hE, 4'h2, 4'h5, 4'h2, 4'h6, 4'h2, 4'hE, 4'h1};
        for (int d = 0; d < 8; d++) begin
            wait_en(~(8'd1 << d), $sformatf("s4_dig%0d", d));
            check($sformatf("s4_dig%0d_num", d), {4'd0, seven_segment_number}, {4'd0, digs[d]});
        end

        // scan timing with one entry
        do_reset();
        send(8'h3A, 1'b0);
        wait_en(8'hFE, "s5_sync");
        check("s5_num_a", {4'd0, seven_segment_number}, 8'h0A);
        fe = 0; fd = 0; ff = 0;
        for (int i = 0; i < 32; i++) begin
            if (seven_segment_enable === 8'hFE) fe++;
            else if (seven_segment_enable === 8'hFD) fd++;
            else if (seven_segment_enable === 8'hFF) ff++;
            if (i == 4) check("s5_num_3", {4'd0, seven_segment_number}, 8'h03);
            if (i == 8) check("s5_after_fd", seven_segment_enable, 8'hFF);
            @(negedge clk);
        end
        check("s5_fe_cycles", 8'(fe), 8'd4);
        check("s5_fd_cycles", 8'(fd), 8'd4);
        check("s5_ff_cycles", 8'(ff), 8'd24);
        check("s5_wrap", seven_segment_enable, 8'hFE);

        // clear together with a make, then reset inside a break sequence
        do_reset();
        send(8'h16, 1'b0); send(8'hF0, 1'b0); send(8'h16, 1'b0);
        send(8'h1E, 1'b1);
        count_blank(32, "s6_clear_blank");
        send(8'hF0, 1'b0);
        do_reset();
        bk0 = bk_seen;
        send(8'h1C, 1'b1);
        check("s6_no_break", {7'd0, break_pulse}, 8'h00);
        check("s6_make_after_reset", {7'd0, make_pulse}, 8'h01);
        count_blank(32, "s6_reset_blank");
        check("s6_break_count", 8'(bk_seen - bk0), 8'd0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
